piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_serializer_pkg.sv | 5 +
 rtl/piso_serializer.sv | 54 +++++
 tb/tb_piso_serializer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/piso_serializer_pkg.sv
// piso_serializer_pkg: FSM states and default word width shared by the serializer and receiver
package piso_serializer_pkg;
  localparam int DEFAULT_WIDTH = 4;
  typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out shifter with valid/ready handshakes on both sides
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  state_t           state, state_nx;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             accept, xfer;
  always_comb begin
    ser_valid  = state == SHIFT;
    busy       = ser_valid;
    ser_last   = ser_valid && cnt == CW'(WIDTH - 1);
    ser_out    = ser_valid ? (LSB_FIRST ? sreg[0] : sreg[WIDTH-1]) : 1'b0;
    xfer       = ser_valid && ser_ready;
    load_ready = state == IDLE || (xfer && ser_last);
    accept     = load_valid && load_ready;
    state_nx   = accept ? SHIFT : (xfer && ser_last) ? IDLE : state;
  end
  // A load on the last-bit edge takes priority, giving zero-gap back-to-back words
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        sreg <= load_data;
        cnt  <= '0;
      end else if (xfer && ser_last) begin
        sreg <= '0;
        cnt  <= '0;
      end else if (xfer) begin
        sreg <= LSB_FIRST ? sreg >> 1 : sreg << 1;
        cnt  <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed checks of an LSB-first and an MSB-first 4-bit serializer
module tb_piso_serializer;
  import piso_serializer_pkg::*;
  logic clk = 1'b0, reset = 1'b1;
  logic lv_a = 1'b0, sr_a = 1'b1, lr_a, so_a, sv_a, sl_a, bz_a;
  logic lv_b = 1'b0, sr_b = 1'b1, lr_b, so_b, sv_b, sl_b, bz_b;
  logic [3:0] ld_a = '0, ld_b = '0;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(DEFAULT_WIDTH), .LSB_FIRST(1'b1)) dut_a (
    .clk(clk), .reset(reset), .load_valid(lv_a), .load_data(ld_a), .load_ready(lr_a),
    .ser_out(so_a), .ser_valid(sv_a), .ser_ready(sr_a), .ser_last(sl_a), .busy(bz_a));

  piso_serializer #(.WIDTH(DEFAULT_WIDTH), .LSB_FIRST(1'b0)) dut_b (
    .clk(clk), .reset(reset), .load_valid(lv_b), .load_data(ld_b), .load_ready(lr_b),
    .ser_out(so_b), .ser_valid(sv_b), .ser_ready(sr_b), .ser_last(sl_b), .busy(bz_b));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; lv_a = 1'b1; ld_a = 4'hF; sr_a = 1'b1;
    #1;
    n_chk++; if (sv_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", sv_a); end
    n_chk++; if (so_a !== 1'b0) begin n_fail++; $display("FAIL reset_out: got %b expected 0", so_a); end
    n_chk++; if (sl_a !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b expected 0", sl_a); end
    n_chk++; if (bz_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bz_a); end
    n_chk++; if (lr_a !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", lr_a); end
    step; step;
    n_chk++; if (sv_a !== 1'b0) begin n_fail++; $display("FAIL reset_noload: got %b expected 0", sv_a); end
    reset = 1'b0;
    step;
    lv_a = 1'b0;
    n_chk++; if (sv_a !== 1'b1) begin n_fail++; $display("FAIL first_load_valid: got %b expected 1", sv_a); end
    n_chk++; if (so_a !== 1'b1) begin n_fail++; $display("FAIL first_load_out: got %b expected 1", so_a); end
    repeat (4) step;
    n_chk++; if (sv_a !== 1'b0) begin n_fail++; $display("FAIL first_load_drain: got %b expected 0", sv_a); end
  endtask

  task automatic test_lsb_first;
    logic [3:0] w;
    w = 4'b1011; ld_a = w; lv_a = 1'b1; sr_a = 1'b1;
    n_chk++; if (lr_a !== 1'b1) begin n_fail++; $display("FAIL lsb_idle_ready: got %b expected 1", lr_a); end
    step;
    lv_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (so_a !== w[i]) begin n_fail++; $display("FAIL lsb_bit%0d: got %b expected %b", i, so_a, w[i]); end
      n_chk++; if (sl_a !== (i == 3)) begin n_fail++; $display("FAIL lsb_last%0d: got %b expected %b", i, sl_a, i == 3); end
      n_chk++; if (bz_a !== 1'b1) begin n_fail++; $display("FAIL lsb_busy%0d: got %b expected 1", i, bz_a); end
      step;
    end
    n_chk++; if (sv_a !== 1'b0) begin n_fail++; $display("FAIL lsb_end_valid: got %b expected 0", sv_a); end
    n_chk++; if (so_a !== 1'b0) begin n_fail++; $display("FAIL lsb_end_out: got %b expected 0", so_a); end
  endtask

  task automatic test_backpressure;
    logic [3:0] w;
    int n;
    w = 4'b0110; ld_a = w; lv_a = 1'b1; sr_a = 1'b1; n = 0;
    step;
    lv_a = 1'b0; sr_a = 1'b0; ld_a = 4'hF;
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (so_a !== 1'b0) begin n_fail++; $display("FAIL bp_hold_out%0d: got %b expected 0", i, so_a); end
      n_chk++; if (sv_a !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid%0d: got %b expected 1", i, sv_a); end
      n_chk++; if (sl_a !== 1'b0) begin n_fail++; $display("FAIL bp_hold_last%0d: got %b expected 0", i, sl_a); end
      step;
    end
    sr_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (so_a !== w[i]) begin n_fail++; $display("FAIL bp_bit%0d: got %b expected %b", i, so_a, w[i]); end
      n_chk++; if (sl_a !== (i == 3)) begin n_fail++; $display("FAIL bp_last%0d: got %b expected %b", i, sl_a, i == 3); end
      if (sv_a && sr_a) n++;
      step;
    end
    n_chk++; if (n != 4) begin n_fail++; $display("FAIL bp_transfers: got %0d expected 4", n); end
    n_chk++; if (sv_a !== 1'b0) begin n_fail++; $display("FAIL bp_end_valid: got %b expected 0", sv_a); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] seq;
    seq = 8'b0101_1010; ld_a = 4'hA; lv_a = 1'b1; sr_a = 1'b1;
    step;
    ld_a = 4'h5;
    for (int i = 0; i < 8; i++) begin
      n_chk++; if (sv_a !== 1'b1) begin n_fail++; $display("FAIL b2b_valid%0d: got %b expected 1", i, sv_a); end
      n_chk++; if (so_a !== seq[i]) begin n_fail++; $display("FAIL b2b_bit%0d: got %b expected %b", i, so_a, seq[i]); end
      n_chk++; if (sl_a !== (i == 3 || i == 7)) begin n_fail++; $display("FAIL b2b_last%0d: got %b expected %b", i, sl_a, i == 3 || i == 7); end
      if (i < 7) begin
        n_chk++; if (lr_a !== (i == 3)) begin n_fail++; $display("FAIL b2b_ready%0d: got %b expected %b", i, lr_a, i == 3); end
      end
      step;
      if (i == 3) lv_a = 1'b0;
    end
    n_chk++; if (sv_a !== 1'b0) begin n_fail++; $display("FAIL b2b_end_valid: got %b expected 0", sv_a); end
  endtask

  task automatic test_msb_first;
    logic [3:0] w;
    w = 4'b1000; ld_b = w; lv_b = 1'b1; sr_b = 1'b1;
    step;
    lv_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (so_b !== w[3-i]) begin n_fail++; $display("FAIL msb_bit%0d: got %b expected %b", i, so_b, w[3-i]); end
      n_chk++; if (sl_b !== (i == 3)) begin n_fail++; $display("FAIL msb_last%0d: got %b expected %b", i, sl_b, i == 3); end
      step;
    end
    n_chk++; if (sv_b !== 1'b0) begin n_fail++; $display("FAIL msb_end_valid: got %b expected 0", sv_b); end
  endtask

  task automatic test_reset_mid_word;
    logic [3:0] w;
    w = 4'b1101; ld_a = w; lv_a = 1'b1; sr_a = 1'b1;
    step;
    lv_a = 1'b0;
    step; step;
    n_chk++; if (so_a !== 1'b1) begin n_fail++; $display("FAIL mid_pre_out: got %b expected 1", so_a); end
    #2 reset = 1'b1;
    #1;
    n_chk++; if (sv_a !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b expected 0", sv_a); end
    n_chk++; if (so_a !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out: got %b expected 0", so_a); end
    n_chk++; if (sl_a !== 1'b0) begin n_fail++; $display("FAIL mid_rst_last: got %b expected 0", sl_a); end
    n_chk++; if (bz_a !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b expected 0", bz_a); end
    step;
    reset = 1'b0; lv_a = 1'b1;
    step;
    lv_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (so_a !== w[i]) begin n_fail++; $display("FAIL mid_restart_bit%0d: got %b expected %b", i, so_a, w[i]); end
      n_chk++; if (sl_a !== (i == 3)) begin n_fail++; $display("FAIL mid_restart_last%0d: got %b expected %b", i, sl_a, i == 3); end
      step;
    end
  endtask

  task automatic test_loopback;
    logic [3:0] rx_a, rx_b;
    rx_a = '0; rx_b = '0;
    ld_a = 4'h3; ld_b = 4'hC; lv_a = 1'b1; lv_b = 1'b1; sr_a = 1'b1; sr_b = 1'b1;
    step;
    lv_a = 1'b0; lv_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (sv_a && sr_a) rx_a = {so_a, rx_a[3:1]};
      if (sv_b && sr_b) rx_b = {rx_b[2:0], so_b};
      step;
    end
    n_chk++; if (rx_a !== 4'h3) begin n_fail++; $display("FAIL loop_lsb: got %h expected 3", rx_a); end
    n_chk++; if (rx_b !== 4'hC) begin n_fail++; $display("FAIL loop_msb: got %h expected c", rx_b); end
    n_chk++; if (sv_a !== 1'b0 || sv_b !== 1'b0) begin n_fail++; $display("FAIL loop_idle: got %b%b expected 00", sv_a, sv_b); end
  endtask

  initial begin
    test_reset;
    test_lsb_first;
    test_backpressure;
    test_back_to_back;
    test_msb_first;
    test_reset_mid_word;
    test_loopback;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
